// File: rtl/slv_i2c_regmap.sv
// slv_i2c_regmap: register-map back end for the I2C slave.
// Decodes the slave address / RW / register-address / data stream coming from
// the slave FSM, answers each byte with an ACK/NACK decision, performs register
// writes with an auto-incrementing pointer and supplies bytes for master reads.
// Ports:
//   CLK, RST_n          clock, asynchronous active-low reset
//   I_ADDR_SLV, I_RW    decoded slave address and RW bit (1 = read)
//   I_ADDR_REG          register-address byte
//   I_DATA_RD           data byte written by the master
//   I_ACK_MSTR          master ACK after a read byte (1 = ACK)
//   I_BYTE_VLD          pulse: a byte has been received, fields stable
//   I_TX_REQ            pulse: a read byte finished, I_ACK_MSTR sampled
//   I_STOP              pulse: STOP or repeated START
//   O_ACK               ACK decision for the 9th bit (1 = ACK)
//   O_DATA_TX           byte to shift out on a read
//   O_WR_STB            one-cycle register write strobe
//   O_WR_ADDR/O_WR_DATA index and data of the current write
//   O_BUSY              transaction in progress
module slv_i2c_regmap #(
  parameter int unsigned          DATA_SZ  = 8,
  parameter logic [DATA_SZ-2:0]   SLV_ADDR = 7'h3C,
  parameter int unsigned          REG_NUM  = 16
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [DATA_SZ-2:0] I_ADDR_SLV,
  input  logic               I_RW,
  input  logic [DATA_SZ-1:0] I_ADDR_REG,
  input  logic [DATA_SZ-1:0] I_DATA_RD,
  input  logic               I_ACK_MSTR,
  input  logic               I_BYTE_VLD,
  input  logic               I_TX_REQ,
  input  logic               I_STOP,
  output logic               O_ACK,
  output logic [DATA_SZ-1:0] O_DATA_TX,
  output logic               O_WR_STB,
  output logic [DATA_SZ-1:0] O_WR_ADDR,
  output logic [DATA_SZ-1:0] O_WR_DATA,
  output logic               O_BUSY
);

  localparam int unsigned        IDX_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [DATA_SZ-1:0] LAST_IDX = DATA_SZ'(REG_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REG_PTR = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_IGNORE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SZ-1:0]   ptr_q, ptr_d;
  logic                 ack_q, ack_d;
  logic [DATA_SZ-1:0]   data_tx_q, data_tx_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [DATA_SZ-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_SZ-1:0]   wr_data_q, wr_data_d;
  logic                 busy_q;
  logic [DATA_SZ-1:0]   mem_q [REG_NUM];
  logic                 mem_we_c;
  logic                 reg_in_range_c;
  logic [DATA_SZ-1:0]   ptr_nx_c;

  // Pointer increment with wrap at the last implemented register
  assign ptr_nx_c       = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
  assign reg_in_range_c = (32'(I_ADDR_REG) < REG_NUM);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    data_tx_d = data_tx_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we_c  = 1'b0;

    // STOP / repeated START wins over any coincident byte or TX request
    if (I_STOP) begin
      state_d = ST_IDLE;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (I_BYTE_VLD) begin
            if (I_ADDR_SLV == SLV_ADDR) begin
              ack_d = 1'b1;
              if (I_RW) begin
                state_d   = ST_READ;
                data_tx_d = mem_q[IDX_W'(ptr_q)];
              end else begin
                state_d = ST_REG_PTR;
              end
            end else begin
              ack_d   = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_REG_PTR: begin
          if (I_BYTE_VLD) begin
            if (reg_in_range_c) begin
              ptr_d   = I_ADDR_REG;
              ack_d   = 1'b1;
              state_d = ST_WRITE;
            end else begin
              ack_d   = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_WRITE: begin
          if (I_BYTE_VLD) begin
            mem_we_c  = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = I_DATA_RD;
            ack_d     = 1'b1;
            ptr_d     = ptr_nx_c;
          end
        end
        ST_READ: begin
          // The byte just sent is consumed whether the master ACKs or NACKs
          if (I_TX_REQ) begin
            ptr_d = ptr_nx_c;
            if (I_ACK_MSTR) begin
              data_tx_d = mem_q[IDX_W'(ptr_nx_c)];
            end else begin
              ack_d   = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_IGNORE: begin
          ack_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      ack_q     <= 1'b0;
      data_tx_q <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      data_tx_q <= data_tx_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Register file
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[IDX_W'(ptr_q)] <= I_DATA_RD;
    end
  end

  assign O_ACK     = ack_q;
  assign O_DATA_TX = data_tx_q;
  assign O_WR_STB  = wr_stb_q;
  assign O_WR_ADDR = wr_addr_q;
  assign O_WR_DATA = wr_data_q;
  assign O_BUSY    = busy_q;

endmodule

// File: tb/tb_slv_i2c_regmap.sv
// Bench for slv_i2c_regmap: directed vector table, hand-written reset sequence
// and randomized transactions checked against a transaction-level model.
module tb_slv_i2c_regmap;

  localparam int unsigned REG_NUM = 16;
  localparam logic [6:0]  SLV     = 7'h3C;

  localparam int K_BYTE = 0, K_TX = 1, K_STOP = 2, K_STOP_BYTE = 3;
  localparam int X = -1;

  logic       CLK, RST_n;
  logic [6:0] I_ADDR_SLV;
  logic       I_RW;
  logic [7:0] I_ADDR_REG, I_DATA_RD;
  logic       I_ACK_MSTR, I_BYTE_VLD, I_TX_REQ, I_STOP;
  logic       O_ACK, O_WR_STB, O_BUSY;
  logic [7:0] O_DATA_TX, O_WR_ADDR, O_WR_DATA;

  slv_i2c_regmap #(.DATA_SZ(8), .SLV_ADDR(SLV), .REG_NUM(REG_NUM)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .I_ADDR_SLV(I_ADDR_SLV), .I_RW(I_RW), .I_ADDR_REG(I_ADDR_REG),
    .I_DATA_RD(I_DATA_RD), .I_ACK_MSTR(I_ACK_MSTR), .I_BYTE_VLD(I_BYTE_VLD),
    .I_TX_REQ(I_TX_REQ), .I_STOP(I_STOP),
    .O_ACK(O_ACK), .O_DATA_TX(O_DATA_TX), .O_WR_STB(O_WR_STB),
    .O_WR_ADDR(O_WR_ADDR), .O_WR_DATA(O_WR_DATA), .O_BUSY(O_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         kind;
    logic [6:0] slv;
    logic       rw;
    logic [7:0] b;
    logic       ackm;
    int         e_ack, e_stb, e_wa, e_wd, e_tx, e_busy;
  } vec_t;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state: register contents and pointer
  int mdl_mem [REG_NUM];
  int mdl_ptr;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t v(input int kind, input logic [6:0] slv, input logic rw,
                             input logic [7:0] b, input logic ackm, input int e_ack,
                             input int e_stb, input int e_wa, input int e_wd,
                             input int e_tx, input int e_busy);
    vec_t r;
    r.kind = kind; r.slv = slv; r.rw = rw; r.b = b; r.ackm = ackm;
    r.e_ack = e_ack; r.e_stb = e_stb; r.e_wa = e_wa; r.e_wd = e_wd;
    r.e_tx = e_tx; r.e_busy = e_busy;
    return r;
  endfunction

  // Drive one pulse for one cycle, then compare the registered outputs
  task automatic apply(input vec_t t, input string tag);
    @(negedge CLK);
    I_ADDR_SLV = t.slv; I_RW = t.rw; I_ADDR_REG = t.b; I_DATA_RD = t.b;
    I_ACK_MSTR = t.ackm;
    I_BYTE_VLD = (t.kind == K_BYTE) || (t.kind == K_STOP_BYTE);
    I_TX_REQ   = (t.kind == K_TX);
    I_STOP     = (t.kind == K_STOP) || (t.kind == K_STOP_BYTE);
    @(negedge CLK);
    I_BYTE_VLD = 1'b0; I_TX_REQ = 1'b0; I_STOP = 1'b0;
    if (t.e_ack  >= 0) chk({tag, " ack"},  int'(O_ACK),     t.e_ack);
    if (t.e_stb  >= 0) chk({tag, " stb"},  int'(O_WR_STB),  t.e_stb);
    if (t.e_stb  == 1) chk({tag, " wadr"}, int'(O_WR_ADDR), t.e_wa);
    if (t.e_stb  == 1) chk({tag, " wdat"}, int'(O_WR_DATA), t.e_wd);
    if (t.e_tx   >= 0) chk({tag, " tx"},   int'(O_DATA_TX), t.e_tx);
    if (t.e_busy >= 0) chk({tag, " busy"}, int'(O_BUSY),    t.e_busy);
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    for (int i = 0; i < REG_NUM; i++) mdl_mem[i] = 0;
    mdl_ptr = 0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"},  int'(O_ACK),     0);
    chk({tag, " tx"},   int'(O_DATA_TX), 0);
    chk({tag, " stb"},  int'(O_WR_STB),  0);
    chk({tag, " wadr"}, int'(O_WR_ADDR), 0);
    chk({tag, " wdat"}, int'(O_WR_DATA), 0);
    chk({tag, " busy"}, int'(O_BUSY),    0);
  endtask

  // Transaction-level model: write transaction (address, register byte, n data bytes, STOP)
  task automatic write_txn(input logic [6:0] slv, input int rg, input int n, input int id);
    bit hit = (slv == SLV);
    bit ok  = hit && (rg < REG_NUM);
    int d;
    apply(v(K_BYTE, slv, 1'b0, 8'($urandom), 1'b0, int'(hit), 0, 0, 0, X, 1),
          $sformatf("rw%0d adr", id));
    apply(v(K_BYTE, slv, 1'b0, 8'(rg), 1'b0, int'(ok), 0, 0, 0, X, 1),
          $sformatf("rw%0d reg", id));
    if (ok) mdl_ptr = rg;
    for (int i = 0; i < n; i++) begin
      d = int'($urandom_range(0, 255));
      apply(v(K_BYTE, slv, 1'b0, 8'(d), 1'b0, int'(ok), int'(ok), mdl_ptr, d, X, 1),
            $sformatf("rw%0d dat%0d", id, i));
      if (ok) begin
        mdl_mem[mdl_ptr] = d;
        mdl_ptr = (mdl_ptr + 1) % REG_NUM;
      end
    end
    apply(v(K_STOP, slv, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0), $sformatf("rw%0d stop", id));
  endtask

  // Transaction-level model: read n bytes from the current pointer, NACK on the last
  task automatic read_txn(input logic [6:0] slv, input int n, input int id);
    bit hit = (slv == SLV);
    bit am;
    int etx;
    etx = hit ? mdl_mem[mdl_ptr] : X;
    apply(v(K_BYTE, slv, 1'b1, 8'($urandom), 1'b0, int'(hit), 0, 0, 0, etx, 1),
          $sformatf("rr%0d adr", id));
    for (int i = 0; i < n; i++) begin
      am  = (i < n - 1);
      etx = (hit && am) ? mdl_mem[(mdl_ptr + i + 1) % REG_NUM] : X;
      apply(v(K_TX, slv, 1'b1, 8'h00, am, am ? X : 0, 0, 0, 0, etx, 1),
            $sformatf("rr%0d tx%0d", id, i));
    end
    if (hit) mdl_ptr = (mdl_ptr + n) % REG_NUM;
    apply(v(K_STOP, slv, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0), $sformatf("rr%0d stop", id));
  endtask

  vec_t tbl[$];

  initial begin
    logic [6:0] s;
    RST_n = 1'b0; I_ADDR_SLV = '0; I_RW = 1'b0; I_ADDR_REG = '0; I_DATA_RD = '0;
    I_ACK_MSTR = 1'b0; I_BYTE_VLD = 1'b0; I_TX_REQ = 1'b0; I_STOP = 1'b0;
    do_reset();
    chk_all_zero("reset");

    // Write burst at reg 2
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h02, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'hA5, 1'b0, 1, 1, 2, 8'hA5, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h5A, 1'b0, 1, 1, 3, 8'h5A, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Pointer set, repeated-start read, ACK then NACK
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h02, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    tbl.push_back(v(K_BYTE, SLV,   1'b1, 8'h00, 1'b0, 1, 0, 0, 0, 8'hA5, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b1, X, 0, 0, 0, 8'h5A, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Put 0xC3 in reg 4, then leave pointer at 4
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h04, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'hC3, 1'b0, 1, 1, 4, 8'hC3, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h04, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Wrong slave address
    tbl.push_back(v(K_BYTE, 7'h3D, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, 7'h3D, 1'b0, 8'h77, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, 7'h3D, 1'b0, 8'h88, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, 7'h3D, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Out-of-range register address
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h10, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h99, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Pointer still 4 and reg 4 unchanged
    tbl.push_back(v(K_BYTE, SLV,   1'b1, 8'h00, 1'b0, 1, 0, 0, 0, 8'hC3, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Wrap-around write at reg 15
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h0F, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h11, 1'b0, 1, 1, 15, 8'h11, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h22, 1'b0, 1, 1, 0, 8'h22, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // Wrap-around read from reg 15
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h0F, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    tbl.push_back(v(K_BYTE, SLV,   1'b1, 8'h00, 1'b0, 1, 0, 0, 0, 8'h11, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b1, X, 0, 0, 0, 8'h22, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b1, X, 0, 0, 0, 8'h00, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    // STOP coincident with a data byte in WRITE: no write
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h06, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP_BYTE, SLV, 1'b0, 8'h77, 1'b0, 0, 0, 0, 0, X, 0));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_BYTE, SLV,   1'b0, 8'h06, 1'b0, 1, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));
    tbl.push_back(v(K_BYTE, SLV,   1'b1, 8'h00, 1'b0, 1, 0, 0, 0, 8'h00, 1));
    tbl.push_back(v(K_TX,   SLV,   1'b1, 8'h00, 1'b0, 0, 0, 0, 0, X, 1));
    tbl.push_back(v(K_STOP, SLV,   1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset in the middle of a write burst
    apply(v(K_BYTE, SLV, 1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1), "arst adr");
    apply(v(K_BYTE, SLV, 1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1), "arst reg");
    apply(v(K_BYTE, SLV, 1'b0, 8'h12, 1'b0, 1, 1, 0, 8'h12, X, 1), "arst dat");
    #2 RST_n = 1'b0;
    #1 chk_all_zero("arst mid");
    do_reset();
    // Reg 2 held 0xA5 before reset; must now read back 0
    apply(v(K_BYTE, SLV, 1'b0, 8'h00, 1'b0, 1, 0, 0, 0, X, 1), "arst2 adr");
    apply(v(K_BYTE, SLV, 1'b0, 8'h02, 1'b0, 1, 0, 0, 0, X, 1), "arst2 reg");
    apply(v(K_STOP, SLV, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0), "arst2 stop");
    apply(v(K_BYTE, SLV, 1'b1, 8'h00, 1'b0, 1, 0, 0, 0, 8'h00, 1), "arst2 rd");
    apply(v(K_STOP, SLV, 1'b0, 8'h00, 1'b0, 0, 0, 0, 0, X, 0), "arst2 stop2");

    // Randomized transactions against the model
    do_reset();
    for (int t = 0; t < 80; t++) begin
      s = SLV;
      if ($urandom_range(0, 5) == 0) begin
        do s = 7'($urandom); while (s == SLV);
      end
      if ($urandom_range(0, 1) == 0)
        write_txn(s, int'($urandom_range(0, 19)), int'($urandom_range(0, 5)), t);
      else
        read_txn(s, int'($urandom_range(1, 5)), t);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
